// File: rtl/xeng_vacc_sp_if.sv
// Streaming bundle between the X-engine output and the long-term vector accumulator.
// master drives the X-engine side; slave is the accumulator's view.
interface xeng_vacc_sp_if #(
    parameter int IN_WIDTH   = 38,
    parameter int OUT_WIDTH  = 64,
    parameter int ACC_BITS   = 16,
    parameter int MCNT_WIDTH = 48
) ();
    logic                  sync_in;
    logic [IN_WIDTH-1:0]   din;
    logic                  vld;
    logic [MCNT_WIDTH-1:0] mcnt;
    logic [ACC_BITS-1:0]   acc_len;
    logic [OUT_WIDTH-1:0]  dout;
    logic                  vld_out;
    logic                  sync_out;
    logic [MCNT_WIDTH-1:0] mcnt_out;
    logic                  ovf_out;

    modport master (
        output sync_in, din, vld, mcnt, acc_len,
        input  dout, vld_out, sync_out, mcnt_out, ovf_out
    );

    modport slave (
        input  sync_in, din, vld, mcnt, acc_len,
        output dout, vld_out, sync_out, mcnt_out, ovf_out
    );
endinterface

// File: rtl/xeng_vacc_sp.sv
// Long-term vector accumulator: sums acc_len X-engine windows per address in RAM with a
// 2-stage read-modify-write, saturating per component, and dumps the last window's sums.
module xeng_vacc_sp #(
    parameter int IN_WIDTH   = 38,
    parameter int OUT_WIDTH  = 64,
    parameter int VEC_LEN    = 60,
    parameter int ACC_BITS   = 16,
    parameter int MCNT_WIDTH = 48
) (
    input logic           clk,
    input logic           rst_n,
    xeng_vacc_sp_if.slave bus
);
    localparam int IH = IN_WIDTH / 2;
    localparam int OH = OUT_WIDTH / 2;
    localparam int SW = ((IH > OH) ? IH : OH) + 1;
    localparam int AW = $clog2(VEC_LEN);

    typedef enum logic [1:0] {IDLE, ARMED, ACC} state_e;

    typedef struct packed {
        logic          ovf;
        logic [OH-1:0] re;
        logic [OH-1:0] im;
    } entry_t;

    function automatic logic [SW-1:0] sext_in(input logic [IH-1:0] x);
        return {{(SW-IH){x[IH-1]}}, x};
    endfunction

    function automatic logic [SW-1:0] sext_acc(input logic [OH-1:0] x);
        return {{(SW-OH){x[OH-1]}}, x};
    endfunction

    // Returns {clipped, value}; the sum fits when every bit above the OH-bit sign agrees with it.
    function automatic logic [OH:0] saturate(input logic [SW-1:0] s);
        logic [SW-OH:0] top;
        top = s[SW-1:OH-1];
        if (&top || ~|top) return {1'b0, s[OH-1:0]};
        return {1'b1, s[SW-1], {(OH-1){~s[SW-1]}}};
    endfunction

    state_e                state_q;
    logic [AW-1:0]         addr_q;
    logic [ACC_BITS-1:0]   win_q;
    logic [ACC_BITS-1:0]   acc_last_q;
    logic [MCNT_WIDTH-1:0] mcnt_pend_q;

    logic                  s1_vld_q;
    logic [AW-1:0]         s1_addr_q;
    logic [IN_WIDTH-1:0]   s1_din_q;
    logic                  s1_first_q;
    logic                  s1_dump_q;

    logic [OUT_WIDTH-1:0]  dout_q;
    logic                  vld_out_q;
    logic                  sync_out_q;
    logic [MCNT_WIDTH-1:0] mcnt_out_q;
    logic                  ovf_out_q;

    entry_t                ram_q [VEC_LEN];
    entry_t                rd_q;

    logic                  accept;
    logic [OH-1:0]         old_re, old_im;
    logic [SW-1:0]         sum_re, sum_im;
    logic [OH:0]           sat_re, sat_im;
    entry_t                wr_d;

    // sync_in wins over a coincident vld: that word belongs to no integration.
    assign accept = bus.vld && !bus.sync_in && (state_q != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            win_q       <= '0;
            acc_last_q  <= '0;
            mcnt_pend_q <= '0;
        end else if (bus.sync_in) begin
            state_q    <= ARMED;
            addr_q     <= '0;
            win_q      <= '0;
            acc_last_q <= (bus.acc_len == '0) ? '0 : bus.acc_len - ACC_BITS'(1);
        end else if (accept) begin
            state_q <= ACC;
            if (win_q == '0 && addr_q == '0) mcnt_pend_q <= bus.mcnt;
            if (addr_q == AW'(VEC_LEN - 1)) begin
                addr_q <= '0;
                win_q  <= (win_q == acc_last_q) ? '0 : win_q + ACC_BITS'(1);
            end else begin
                addr_q <= addr_q + AW'(1);
            end
        end
    end

    // NOTE: the accumulator RAM and its read register are not reset; window 0 never uses the stored value.
    always_ff @(posedge clk) begin
        if (accept)   rd_q <= ram_q[addr_q];
        if (s1_vld_q) ram_q[s1_addr_q] <= wr_d;
    end

    // NOTE: every combinational output is assigned on every path so no latch is inferred.
    always_comb begin
        old_re     = s1_first_q ? '0 : rd_q.re;
        old_im     = s1_first_q ? '0 : rd_q.im;
        sum_re     = sext_acc(old_re) + sext_in(s1_din_q[IN_WIDTH-1:IH]);
        sum_im     = sext_acc(old_im) + sext_in(s1_din_q[IH-1:0]);
        sat_re     = saturate(sum_re);
        sat_im     = saturate(sum_im);
        wr_d.re    = sat_re[OH-1:0];
        wr_d.im    = sat_im[OH-1:0];
        wr_d.ovf   = sat_re[OH] | sat_im[OH] | (!s1_first_q && rd_q.ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_addr_q  <= '0;
            s1_din_q   <= '0;
            s1_first_q <= 1'b0;
            s1_dump_q  <= 1'b0;
            dout_q     <= '0;
            vld_out_q  <= 1'b0;
            sync_out_q <= 1'b0;
            mcnt_out_q <= '0;
            ovf_out_q  <= 1'b0;
        end else begin
            s1_vld_q <= accept;
            if (accept) begin
                s1_addr_q  <= addr_q;
                s1_din_q   <= bus.din;
                s1_first_q <= (win_q == '0);
                s1_dump_q  <= (win_q == acc_last_q);
            end
            vld_out_q  <= s1_vld_q && s1_dump_q;
            sync_out_q <= s1_vld_q && s1_dump_q && (s1_addr_q == '0);
            if (s1_vld_q && s1_dump_q) begin
                dout_q    <= {wr_d.re, wr_d.im};
                ovf_out_q <= wr_d.ovf;
                if (s1_addr_q == '0) mcnt_out_q <= mcnt_pend_q;
            end
        end
    end

    assign bus.dout     = dout_q;
    assign bus.vld_out  = vld_out_q;
    assign bus.sync_out = sync_out_q;
    assign bus.mcnt_out = mcnt_out_q;
    assign bus.ovf_out  = ovf_out_q;
endmodule

// File: tb/tb_xeng_vacc_sp.sv
// Self-checking bench for xeng_vacc_sp: a full-size instance and a narrow-output instance,
// driven by directed and random windows and compared against a per-address sum model.
module tb_xeng_vacc_sp;
    localparam int IW  = 38;
    localparam int IH  = 19;
    localparam int MW  = 48;
    localparam int VL0 = 60;
    localparam int OW0 = 64;
    localparam int VL1 = 8;
    localparam int OW1 = 24;

    typedef struct {
        int     dut;
        int     due;
        longint re;
        longint im;
        bit     ovf;
        bit     sync;
        longint mcnt;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xeng_vacc_sp_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW0), .ACC_BITS(16), .MCNT_WIDTH(MW)) b0 ();
    xeng_vacc_sp_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW1), .ACC_BITS(16), .MCNT_WIDTH(MW)) b1 ();

    xeng_vacc_sp #(.IN_WIDTH(IW), .OUT_WIDTH(OW0), .VEC_LEN(VL0), .ACC_BITS(16), .MCNT_WIDTH(MW))
        u_big (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    xeng_vacc_sp #(.IN_WIDTH(IW), .OUT_WIDTH(OW1), .VEC_LEN(VL1), .ACC_BITS(16), .MCNT_WIDTH(MW))
        u_small (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    // Reference model: integer sums per address, clipped after every add.
    int     sel = 0;
    int     m_vl = VL0;
    int     m_oh = OW0 / 2;
    bit     m_armed = 1'b0;
    int     m_last = 0;
    int     m_addr = 0;
    int     m_win = 0;
    longint m_mcnt = 0;
    longint m_re [64];
    longint m_im [64];
    bit     m_ovf [64];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint clip(input longint v, input int oh, output bit o);
        longint mx, mn;
        mx = (longint'(1) <<< (oh - 1)) - 1;
        mn = -(longint'(1) <<< (oh - 1));
        o  = (v > mx) || (v < mn);
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    function automatic longint rnd();
        return longint'($urandom_range(0, 524287)) - 262144;
    endfunction

    task automatic model_word(input longint re, input longint im, input longint mc);
        bit   o_re, o_im;
        exp_t e;
        if (m_win == 0 && m_addr == 0) m_mcnt = mc;
        if (m_win == 0) begin
            m_re[m_addr]  = 0;
            m_im[m_addr]  = 0;
            m_ovf[m_addr] = 1'b0;
        end
        m_re[m_addr]  = clip(m_re[m_addr] + re, m_oh, o_re);
        m_im[m_addr]  = clip(m_im[m_addr] + im, m_oh, o_im);
        m_ovf[m_addr] = m_ovf[m_addr] | o_re | o_im;
        if (m_win == m_last) begin
            e.dut  = sel;
            e.due  = cyc + 2;
            e.re   = m_re[m_addr];
            e.im   = m_im[m_addr];
            e.ovf  = m_ovf[m_addr];
            e.sync = (m_addr == 0);
            e.mcnt = m_mcnt;
            exp_q.push_back(e);
        end
        m_addr++;
        if (m_addr == m_vl) begin
            m_addr = 0;
            m_win  = (m_win == m_last) ? 0 : m_win + 1;
        end
    endtask

    // One clock of stimulus to the selected instance; called #1 after a rising edge.
    task automatic drive(input bit v, input bit s, input longint re, input longint im,
                         input longint mc, input int al);
        logic [IW-1:0] din;
        din = {IH'(re), IH'(im)};
        b0.din = din; b0.mcnt = MW'(mc); b0.acc_len = 16'(al);
        b1.din = din; b1.mcnt = MW'(mc); b1.acc_len = 16'(al);
        b0.vld = (sel == 0) && v; b0.sync_in = (sel == 0) && s;
        b1.vld = (sel == 1) && v; b1.sync_in = (sel == 1) && s;
        if (s) begin
            m_armed = 1'b1;
            m_last  = (al == 0) ? 0 : al - 1;
            m_addr  = 0;
            m_win   = 0;
        end else if (v && m_armed) begin
            model_word(re, im, mc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic mon(input int d, input bit v, input bit s, input longint re, input longint im,
                       input bit ovf, input longint mc);
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].dut == d && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk($sformatf("d%0d vld_out", d), longint'(v), 1);
            chk($sformatf("d%0d dout.re", d), re, e.re);
            chk($sformatf("d%0d dout.im", d), im, e.im);
            chk($sformatf("d%0d ovf_out", d), longint'(ovf), longint'(e.ovf));
            chk($sformatf("d%0d sync_out", d), longint'(s), longint'(e.sync));
            chk($sformatf("d%0d mcnt_out", d), mc, e.mcnt);
        end else begin
            chk($sformatf("d%0d idle vld_out", d), longint'(v), 0);
            chk($sformatf("d%0d idle sync_out", d), longint'(s), 0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, b0.vld_out, b0.sync_out, longint'($signed(b0.dout[63:32])),
            longint'($signed(b0.dout[31:0])), b0.ovf_out, longint'(b0.mcnt_out));
        mon(1, b1.vld_out, b1.sync_out, longint'($signed(b1.dout[23:12])),
            longint'($signed(b1.dout[11:0])), b1.ovf_out, longint'(b1.mcnt_out));
    end

    initial begin
        int al;
        int n;
        bit v;

        // Reset values
        b0.vld = 0; b0.sync_in = 0; b0.din = '0; b0.mcnt = '0; b0.acc_len = '0;
        b1.vld = 0; b1.sync_in = 0; b1.din = '0; b1.mcnt = '0; b1.acc_len = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset dout", longint'(b0.dout), 0);
        chk("reset vld_out", longint'(b0.vld_out), 0);
        chk("reset sync_out", longint'(b0.sync_out), 0);
        chk("reset mcnt_out", longint'(b0.mcnt_out), 0);
        chk("reset ovf_out", longint'(b0.ovf_out), 0);
        chk("reset small dout", longint'(b1.dout), 0);
        rst_n = 1'b1;

        // vld without any sync is ignored
        for (int i = 0; i < 500; i++) drive(1'b1, 1'b0, rnd(), rnd(), i, 0);

        // acc_len=4, constant (+3,-2), integration starting at mcnt=100
        drive(1'b0, 1'b1, 0, 0, 0, 4);
        for (int i = 0; i < 4 * VL0; i++) drive(1'b1, 1'b0, 3, -2, 100 + i, 0);
        idle(4);

        // acc_len=1 echoes (addr,-addr) every window
        drive(1'b0, 1'b1, 0, 0, 0, 1);
        for (int i = 0; i < 3 * VL0; i++) drive(1'b1, 1'b0, i % VL0, -(i % VL0), 1000 + i, 0);
        idle(4);

        // acc_len=2 with vld toggling
        drive(1'b0, 1'b1, 0, 0, 0, 2);
        for (int i = 0; i < 4 * VL0; i++) drive(i % 2 == 0, 1'b0, rnd(), rnd(), 2000 + i, 0);
        idle(4);

        // acc_len=3, restart at win=1 addr=17: partial integration is discarded
        drive(1'b0, 1'b1, 0, 0, 0, 3);
        for (int i = 0; i < VL0 + 17; i++) drive(1'b1, 1'b0, rnd(), rnd(), 3000 + i, 0);
        drive(1'b0, 1'b1, 0, 0, 0, 3);
        for (int i = 0; i < 3 * VL0; i++) drive(1'b1, 1'b0, rnd(), rnd(), 4000 + i, 0);
        idle(4);

        // acc_len=0 acts as 1
        drive(1'b0, 1'b1, 0, 0, 0, 0);
        for (int i = 0; i < VL0; i++) drive(1'b1, 1'b0, rnd(), rnd(), 5000 + i, 0);
        idle(4);

        // Random acc_len with random gaps, running two integrations back to back
        al = $urandom_range(2, 5);
        drive(1'b0, 1'b1, 0, 0, 0, al);
        n = 0;
        while (n < 2 * al * VL0) begin
            v = ($urandom_range(0, 3) != 0);
            drive(v, 1'b0, rnd(), rnd(), 6000 + n, 0);
            if (v) n++;
        end
        idle(4);

        // Narrow output: saturating integration followed by a clean one
        sel = 1; m_vl = VL1; m_oh = OW1 / 2;
        drive(1'b0, 1'b1, 0, 0, 0, 16);
        for (int i = 0; i < 16 * VL1; i++) drive(1'b1, 1'b0, 262143, -262144, 7000 + i, 0);
        for (int i = 0; i < 16 * VL1; i++) drive(1'b1, 1'b0, 1, -1, 8000 + i, 0);
        idle(4);

        // Reset mid-dump clears outputs; output then needs a new sync
        sel = 0; m_vl = VL0; m_oh = OW0 / 2;
        drive(1'b0, 1'b1, 0, 0, 0, 1);
        for (int i = 0; i < 30; i++) drive(1'b1, 1'b0, rnd(), rnd(), 9000 + i, 0);
        rst_n = 1'b0;
        exp_q.delete();
        m_armed = 1'b0;
        #1;
        chk("mid reset vld_out", longint'(b0.vld_out), 0);
        chk("mid reset dout", longint'(b0.dout), 0);
        chk("mid reset mcnt_out", longint'(b0.mcnt_out), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, rnd(), rnd(), 9500 + i, 0);
        drive(1'b0, 1'b1, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, rnd(), rnd(), 9800 + i, 0);
        idle(4);

        chk("expected words outstanding", longint'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
